result_slot_allocator: RTL and testbench

RESULT_SLOT_ALLOCATOR -- requirements
Module: result_slot_allocator

---
 rtl/result_pkg.sv | 18 +
 rtl/result_slot_tracker.sv | 53 +++++
 rtl/result_slot_allocator.sv | 117 +++++++++++
 tb/tb_result_slot_allocator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared types and defaults for the result slot allocator.
package result_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_SLOTS   = 5;
  localparam int unsigned DEF_SLOT_STRIDE = 1550;

  // Slot index width, never narrower than one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_slot_tracker.sv
// Occupancy vector for the output-FIFO slots with commit/release arbitration
// and a same-cycle release bypass for the next-slot free check.
module result_slot_tracker
  import result_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int unsigned IDX_W     = calc_idx_w(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 commit_en,
  input  logic [IDX_W-1:0]     commit_idx,
  input  logic                 rel_valid,
  input  logic [IDX_W-1:0]     rel_idx,
  input  logic [IDX_W-1:0]     nxt_idx,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 next_free
);

  logic [NUM_SLOTS-1:0] r_occ;
  logic [NUM_SLOTS-1:0] w_commit_mask;
  logic [NUM_SLOTS-1:0] w_rel_mask;
  logic [NUM_SLOTS-1:0] w_nxt_mask;

  // Decoding by loop means out-of-range release indices simply match nothing.
  always_comb begin
    w_commit_mask = '0;
    w_rel_mask    = '0;
    w_nxt_mask    = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (commit_en && (commit_idx == IDX_W'(i))) w_commit_mask[i] = 1'b1;
      if (rel_valid && (rel_idx == IDX_W'(i)))    w_rel_mask[i]    = 1'b1;
      if (nxt_idx == IDX_W'(i))                   w_nxt_mask[i]    = 1'b1;
    end
  end

  // A slot being committed this cycle is never free, even if also released.
  always_comb begin
    next_free = ~|(w_nxt_mask & w_commit_mask) &&
                ~|(w_nxt_mask & r_occ & ~w_rel_mask);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_occ <= '0;
    end else begin
      r_occ <= (r_occ & ~w_rel_mask) | w_commit_mask;
    end
  end

  assign occupied = r_occ;

endmodule

// File: rtl/result_slot_allocator.sv
// Round-robin output-FIFO slot allocator with accumulator-based addressing.
// Optional RESULT_OVERFLOW_CNT_EN adds a saturating stall-overflow counter.
module result_slot_allocator
  import result_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter  int unsigned SLOT_STRIDE = DEF_SLOT_STRIDE,
  parameter  int unsigned BASE_ADDR   = 0,
  parameter  int unsigned ADDR_W      = 32,
  localparam int unsigned IDX_W       = calc_idx_w(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 inc_addr,
  input  logic                 rel_valid,
  input  logic [IDX_W-1:0]     rel_idx,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 write_enable,
  output logic [IDX_W-1:0]     slot_idx,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 full
`ifdef RESULT_OVERFLOW_CNT_EN
  ,
  output logic [15:0]          overflow_cnt
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_slot;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [IDX_W-1:0]    w_nxt;
  logic                w_commit;
  logic                w_advance;
  logic                w_next_free;

  assign w_nxt = (r_slot == IDX_W'(NUM_SLOTS - 1)) ? '0 : r_slot + IDX_W'(1);

  result_slot_tracker #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_tracker (
    .clk        (clk),
    .n_rst      (n_rst),
    .commit_en  (w_commit),
    .commit_idx (r_slot),
    .rel_valid  (rel_valid),
    .rel_idx    (rel_idx),
    .nxt_idx    (w_nxt),
    .occupied   (occupied),
    .next_free  (w_next_free)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ARM: w_state_nxt = WAIT;
      WAIT: begin
        if (inc_addr) begin
          w_commit = 1'b1;
          if (w_next_free) begin
            w_advance   = 1'b1;
            w_state_nxt = ARM;
          end else begin
            w_state_nxt = STALL;
          end
        end
      end
      STALL: begin
        if (w_next_free) begin
          w_advance   = 1'b1;
          w_state_nxt = ARM;
        end
      end
      default: w_state_nxt = ARM;
    endcase
  end

  // write_enable is registered off ARM, so it is high in the cycle after ARM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ARM;
      r_slot  <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= (r_state == ARM);
      if (w_advance) begin
        r_slot <= w_nxt;
        r_addr <= (w_nxt == '0) ? ADDR_W'(BASE_ADDR) : r_addr + ADDR_W'(SLOT_STRIDE);
      end
    end
  end

`ifdef RESULT_OVERFLOW_CNT_EN
  logic [15:0] r_ovf;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= '0;
    end else if ((r_state == STALL) && inc_addr && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  assign overflow_cnt = r_ovf;
`endif

  assign addr_out     = r_addr;
  assign write_enable = r_we;
  assign slot_idx     = r_slot;
  assign full         = (r_state == STALL);

endmodule

// File: tb/tb_result_slot_allocator.sv
// Directed self-checking bench for result_slot_allocator (default and 1-slot builds).
module tb_result_slot_allocator;

  logic        clk;
  logic        n_rst;
  logic        inc_addr;
  logic        rel_valid;
  logic [2:0]  rel_idx;
  logic [31:0] addr_out;
  logic        write_enable;
  logic [2:0]  slot_idx;
  logic [4:0]  occupied;
  logic        full;

  logic        inc1;
  logic        relv1;
  logic [0:0]  reli1;
  logic [31:0] addr1;
  logic        we1;
  logic [0:0]  slot1;
  logic [0:0]  occ1;
  logic        full1;

`ifdef RESULT_OVERFLOW_CNT_EN
  logic [15:0] overflow_cnt;
  logic [15:0] overflow_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  result_slot_allocator #(
    .NUM_SLOTS   (5),
    .SLOT_STRIDE (1550),
    .BASE_ADDR   (0),
    .ADDR_W      (32)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .inc_addr     (inc_addr),
    .rel_valid    (rel_valid),
    .rel_idx      (rel_idx),
    .addr_out     (addr_out),
    .write_enable (write_enable),
    .slot_idx     (slot_idx),
    .occupied     (occupied),
    .full         (full)
`ifdef RESULT_OVERFLOW_CNT_EN
    ,
    .overflow_cnt (overflow_cnt)
`endif
  );

  result_slot_allocator #(
    .NUM_SLOTS   (1),
    .SLOT_STRIDE (1550),
    .BASE_ADDR   (0),
    .ADDR_W      (32)
  ) dut_one (
    .clk          (clk),
    .n_rst        (n_rst),
    .inc_addr     (inc1),
    .rel_valid    (relv1),
    .rel_idx      (reli1),
    .addr_out     (addr1),
    .write_enable (we1),
    .slot_idx     (slot1),
    .occupied     (occ1),
    .full         (full1)
`ifdef RESULT_OVERFLOW_CNT_EN
    ,
    .overflow_cnt (overflow_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr [5];

  initial begin
    exp_addr[0] = 32'd1550;
    exp_addr[1] = 32'd3100;
    exp_addr[2] = 32'd4650;
    exp_addr[3] = 32'd6200;
    exp_addr[4] = 32'd0;

    n_rst = 1'b0; inc_addr = 1'b0; rel_valid = 1'b0; rel_idx = '0;
    inc1 = 1'b0; relv1 = 1'b0; reli1 = '0;
    step(); step();
    chk("rst_addr", addr_out, 32'd0);
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_slot", {29'd0, slot_idx}, 32'd0);
    chk("rst_occ", {27'd0, occupied}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
`ifdef RESULT_OVERFLOW_CNT_EN
    chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
`endif
    n_rst = 1'b1;
    step();
    chk("first_we", {31'd0, write_enable}, 32'd1);
    chk("first_we_one", {31'd0, we1}, 32'd1);

    // Commit then release each slot, stepping around the ring.
    for (int i = 0; i < 5; i++) begin
      inc_addr = 1'b1;
      step();
      inc_addr = 1'b0;
      chk($sformatf("ring_addr%0d", i), addr_out, exp_addr[i]);
      chk($sformatf("ring_we_lo%0d", i), {31'd0, write_enable}, 32'd0);
      chk($sformatf("ring_full%0d", i), {31'd0, full}, 32'd0);
      step();
      chk($sformatf("ring_we_hi%0d", i), {31'd0, write_enable}, 32'd1);
      rel_valid = 1'b1; rel_idx = 3'(i);
      step();
      rel_valid = 1'b0;
      chk($sformatf("ring_occ%0d", i), {27'd0, occupied}, 32'd0);
      chk($sformatf("ring_we_end%0d", i), {31'd0, write_enable}, 32'd0);
      step();
    end

    // Fill all five slots without releasing.
    for (int k = 0; k < 4; k++) begin
      inc_addr = 1'b1;
      step();
      inc_addr = 1'b0;
      chk($sformatf("fill_addr%0d", k), addr_out, exp_addr[k]);
      step();
    end
    inc_addr = 1'b1;
    step();
    chk("stall_full", {31'd0, full}, 32'd1);
    chk("stall_occ", {27'd0, occupied}, 32'h1f);
    chk("stall_addr", addr_out, 32'd6200);
    chk("stall_slot", {29'd0, slot_idx}, 32'd4);
    step(); step(); step();
    inc_addr = 1'b0;
    chk("stall_hold_slot", {29'd0, slot_idx}, 32'd4);
    chk("stall_hold_occ", {27'd0, occupied}, 32'h1f);
`ifdef RESULT_OVERFLOW_CNT_EN
    chk("ovf_cnt3", {16'd0, overflow_cnt}, 32'd3);
`endif
    rel_valid = 1'b1; rel_idx = 3'd7;
    step();
    rel_valid = 1'b0;
    chk("rel7_occ", {27'd0, occupied}, 32'h1f);
    chk("rel7_full", {31'd0, full}, 32'd1);
`ifdef RESULT_OVERFLOW_CNT_EN
    chk("rel7_ovf", {16'd0, overflow_cnt}, 32'd3);
`endif

    // Releasing the blocking slot resumes at slot 0.
    rel_valid = 1'b1; rel_idx = 3'd0;
    step();
    rel_valid = 1'b0;
    chk("unstall_full", {31'd0, full}, 32'd0);
    chk("unstall_slot", {29'd0, slot_idx}, 32'd0);
    chk("unstall_addr", addr_out, 32'd0);
    chk("unstall_occ", {27'd0, occupied}, 32'h1e);
    step();
    chk("unstall_we", {31'd0, write_enable}, 32'd1);

    // Commit slot 0 while releasing occupied slot 1: direct advance.
    inc_addr = 1'b1; rel_valid = 1'b1; rel_idx = 3'd1;
    step();
    inc_addr = 1'b0; rel_valid = 1'b0;
    chk("bypass_full", {31'd0, full}, 32'd0);
    chk("bypass_slot", {29'd0, slot_idx}, 32'd1);
    chk("bypass_addr", addr_out, 32'd1550);
    chk("bypass_occ", {27'd0, occupied}, 32'h1d);
    step();
    chk("bypass_we", {31'd0, write_enable}, 32'd1);

    // Commit and release of the same slot: commit wins, slot 2 blocks.
    inc_addr = 1'b1; rel_valid = 1'b1; rel_idx = 3'd1;
    step();
    inc_addr = 1'b0; rel_valid = 1'b0;
    chk("samecyc_occ", {27'd0, occupied}, 32'h1f);
    chk("samecyc_full", {31'd0, full}, 32'd1);
    chk("samecyc_addr", addr_out, 32'd1550);

    // Asynchronous reset in the middle of a stall.
    n_rst = 1'b0;
    #2;
    chk("midrst_occ", {27'd0, occupied}, 32'd0);
    chk("midrst_addr", addr_out, 32'd0);
    chk("midrst_full", {31'd0, full}, 32'd0);
    chk("midrst_slot", {29'd0, slot_idx}, 32'd0);
    chk("midrst_we", {31'd0, write_enable}, 32'd0);
`ifdef RESULT_OVERFLOW_CNT_EN
    chk("midrst_ovf", {16'd0, overflow_cnt}, 32'd0);
`endif
    #2;
    n_rst = 1'b1;
    step();
    chk("postrst_we", {31'd0, write_enable}, 32'd1);
    chk("postrst_full", {31'd0, full}, 32'd0);
    chk("one_postrst_we", {31'd0, we1}, 32'd1);

    // Single-slot build: every commit stalls until slot 0 is released.
    inc1 = 1'b1;
    step();
    inc1 = 1'b0;
    chk("one_full", {31'd0, full1}, 32'd1);
    chk("one_occ", {31'd0, occ1}, 32'd1);
    chk("one_addr", addr1, 32'd0);
    step();
    chk("one_hold", {31'd0, full1}, 32'd1);
    relv1 = 1'b1; reli1 = 1'b0;
    step();
    relv1 = 1'b0;
    chk("one_unstall", {31'd0, full1}, 32'd0);
    chk("one_occ_clr", {31'd0, occ1}, 32'd0);
    chk("one_slot", {31'd0, slot1}, 32'd0);
    step();
    chk("one_we", {31'd0, we1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
